// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between N Wishbone masters, the round-robin arbiter and one shared slave.
// "master" is the arbiter's view (it masters the shared slave); "slave" is the surrounding system's view.
interface wb_rr_arbiter_if #(
    parameter int N_MASTERS     = 2,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32
);
    localparam int SW = WB_DATA_WIDTH / 8;

    // Master side: slice i belongs to master i.
    logic [N_MASTERS*WB_ADDR_WIDTH-1:0] m_ADR;
    logic [N_MASTERS*WB_DATA_WIDTH-1:0] m_DAT_W;
    logic [N_MASTERS*SW-1:0]            m_SEL;
    logic [N_MASTERS*3-1:0]             m_CTI;
    logic [N_MASTERS*2-1:0]             m_BTE;
    logic [N_MASTERS-1:0]               m_CYC;
    logic [N_MASTERS-1:0]               m_STB;
    logic [N_MASTERS-1:0]               m_WE;
    logic [N_MASTERS*WB_DATA_WIDTH-1:0] m_DAT_R;
    logic [N_MASTERS-1:0]               m_ACK;
    logic [N_MASTERS-1:0]               m_ERR;

    // Shared slave side.
    logic [WB_ADDR_WIDTH-1:0] s_ADR;
    logic [WB_DATA_WIDTH-1:0] s_DAT_W;
    logic [SW-1:0]            s_SEL;
    logic [2:0]               s_CTI;
    logic [1:0]               s_BTE;
    logic                     s_CYC;
    logic                     s_STB;
    logic                     s_WE;
    logic [WB_DATA_WIDTH-1:0] s_DAT_R;
    logic                     s_ACK;
    logic                     s_ERR;

    // Handshake: a slave phase completes on any cycle with s_CYC & s_STB & (s_ACK | s_ERR);
    // only the granted master sees that completion on its m_ACK/m_ERR bit.
    modport master (
        input  m_ADR, m_DAT_W, m_SEL, m_CTI, m_BTE, m_CYC, m_STB, m_WE,
        output m_DAT_R, m_ACK, m_ERR,
        output s_ADR, s_DAT_W, s_SEL, s_CTI, s_BTE, s_CYC, s_STB, s_WE,
        input  s_DAT_R, s_ACK, s_ERR
    );

    modport slave (
        output m_ADR, m_DAT_W, m_SEL, m_CTI, m_BTE, m_CYC, m_STB, m_WE,
        input  m_DAT_R, m_ACK, m_ERR,
        input  s_ADR, s_DAT_W, s_SEL, s_CTI, s_BTE, s_CYC, s_STB, s_WE,
        output s_DAT_R, s_ACK, s_ERR
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave, grant held for a whole CYC,
// with an optional STB-to-ACK watchdog that answers the stuck master with a one-cycle ERR.
module wb_rr_arbiter #(
    parameter int N_MASTERS     = 2,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    wb_rr_arbiter_if.master      bus,
    output logic [N_MASTERS-1:0] gnt,
    output logic                 timeout_err,
    output logic                 state_o
);
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [IW-1:0]          last_q, last_d;
    logic [WW-1:0]          wait_q, wait_d;

    logic                   owned;
    logic                   expire_win;
    logic                   g_cyc;
    logic                   g_stb;
    logic                   s_stb;
    logic                   fire;

    // Outputs are gated by rstn so nothing leaks to the bus in the reset cycle itself.
    assign owned      = rstn && (state_q == OWNED);
    assign expire_win = (TIMEOUT != 0) && owned && (wait_q == WW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= IW'(N_MASTERS - 1);
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        logic [IW-1:0] pick;
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        wait_d  = wait_q;
        found   = 1'b0;
        cand    = '0;
        pick    = last_q;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                for (int k = 1; k <= N_MASTERS; k++) begin
                    cand = IW'((int'(last_q) + k) % N_MASTERS);
                    if (!found && bus.m_CYC[cand]) begin
                        found = 1'b1;
                        pick  = cand;
                    end
                end
                if (found) begin
                    state_d     = OWNED;
                    idx_d       = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                end
            end
            OWNED: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    last_d  = idx_q;
                    gnt_d   = '0;
                    wait_d  = '0;
                end else if (!s_stb || bus.s_ACK || bus.s_ERR) begin
                    wait_d = '0;
                end else if (wait_q != {WW{1'b1}}) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ADR   = '0;
        bus.s_DAT_W = '0;
        bus.s_SEL   = '0;
        bus.s_CTI   = '0;
        bus.s_BTE   = '0;
        bus.s_WE    = 1'b0;
        g_cyc       = 1'b0;
        g_stb       = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (idx_q == IW'(i)) begin
                bus.s_ADR   = bus.m_ADR[i*AW +: AW];
                bus.s_DAT_W = bus.m_DAT_W[i*DW +: DW];
                bus.s_SEL   = bus.m_SEL[i*SW +: SW];
                bus.s_CTI   = bus.m_CTI[i*3 +: 3];
                bus.s_BTE   = bus.m_BTE[i*2 +: 2];
                bus.s_WE    = bus.m_WE[i];
                g_cyc       = bus.m_CYC[i];
                g_stb       = bus.m_STB[i];
            end
        end
        // The expiry cycle takes the slave off the bus; a same-cycle ACK still wins.
        bus.s_CYC   = owned && g_cyc && !expire_win;
        s_stb       = owned && g_cyc && g_stb && !expire_win;
        bus.s_STB   = s_stb;
        fire        = expire_win && g_cyc && g_stb && !bus.s_ACK;
        bus.m_ACK   = owned ? (gnt_q & {N_MASTERS{bus.s_ACK}}) : '0;
        bus.m_ERR   = owned ? (gnt_q & {N_MASTERS{bus.s_ERR || fire}}) : '0;
        bus.m_DAT_R = {N_MASTERS{bus.s_DAT_R}};
        gnt         = gnt_q;
        timeout_err = fire;
        state_o     = state_q;
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter with four masters and an 8-cycle watchdog.
module tb_wb_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) bus();

    logic [N-1:0] gnt;
    logic         timeout_err;
    logic         state;

    wb_rr_arbiter #(.N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .gnt(gnt), .timeout_err(timeout_err), .state_o(state)
    );

    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [AW-1:0]   m_adr [N];
    logic [DW-1:0]   m_dat [N];
    logic [2:0]      m_cti [N];
    logic            ack_en, ack_force, err_force;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign bus.m_ADR[i*AW +: AW]   = m_adr[i];
        assign bus.m_DAT_W[i*DW +: DW] = m_dat[i];
        assign bus.m_SEL[i*SW +: SW]   = {SW{1'b1}};
        assign bus.m_CTI[i*3 +: 3]     = m_cti[i];
        assign bus.m_BTE[i*2 +: 2]     = 2'b00;
    end
    assign bus.m_CYC   = m_cyc;
    assign bus.m_STB   = m_stb;
    assign bus.m_WE    = m_we;
    // Slave model: zero-wait ack when enabled, read data derived from the address.
    assign bus.s_ACK   = (ack_en & bus.s_CYC & bus.s_STB) | ack_force;
    assign bus.s_ERR   = err_force;
    assign bus.s_DAT_R = bus.s_ADR ^ 32'hCAFE_0000;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] cyc;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_ack;
    } vec_t;
    vec_t tbl [15];
    logic [2*N-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] home_adr(input int i);
        return 32'h100 + 32'(i * 16);
    endfunction

    function automatic logic [AW-1:0] exp_adr(input logic [N-1:0] oh);
        logic [AW-1:0] a;
        a = '0;
        for (int i = 0; i < N; i++) if (oh[i]) a = home_adr(i);
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*N-1:0] e;
        int acks;
        tbl[0]  = '{4'b1111, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b0001, 4'b0001};
        tbl[2]  = '{4'b1110, 4'b0001, 4'b0000};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b1111, 4'b0010, 4'b0010};
        tbl[5]  = '{4'b1101, 4'b0010, 4'b0000};
        tbl[6]  = '{4'b1111, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b1111, 4'b0100, 4'b0100};
        tbl[8]  = '{4'b1011, 4'b0100, 4'b0000};
        tbl[9]  = '{4'b1111, 4'b0000, 4'b0000};
        tbl[10] = '{4'b1111, 4'b1000, 4'b1000};
        tbl[11] = '{4'b0111, 4'b1000, 4'b0000};
        tbl[12] = '{4'b1111, 4'b0000, 4'b0000};
        tbl[13] = '{4'b1111, 4'b0001, 4'b0001};
        tbl[14] = '{4'b1110, 4'b0001, 4'b0000};

        // Reset with requests pending: everything must stay quiet.
        rstn = 1'b0; ack_en = 1'b1; ack_force = 1'b0; err_force = 1'b0;
        m_cyc = 4'b1111; m_stb = 4'b1111; m_we = '0;
        for (int i = 0; i < N; i++) begin
            m_adr[i] = home_adr(i);
            m_dat[i] = 32'($urandom_range(0, 32'h7FFF_FFFF));
            m_cti[i] = 3'b000;
        end
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_s_cyc", bus.s_CYC, 0);
        chk("rst_s_stb", bus.s_STB, 0);
        chk("rst_m_ack", bus.m_ACK, 0);
        chk("rst_m_err", bus.m_ERR, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_state", state, 0);
        next_cycle();
        rstn = 1'b1; m_cyc = '0; m_stb = '0;

        // Simultaneous request from masters 0 and 1; master 0 writes 0x10.
        m_cyc = 4'b0011; m_stb = 4'b0011; m_we[0] = 1'b1; m_adr[0] = 32'h10;
        m_dat[0] = 32'h1234_5678;
        @(negedge clk);
        chk("pair_latency_gnt", gnt, 0);
        chk("pair_latency_s_cyc", bus.s_CYC, 0);
        next_cycle();
        @(negedge clk);
        chk("pair_gnt0", gnt, 4'b0001);
        chk("pair_s_cyc", bus.s_CYC, 1);
        chk("pair_s_adr", bus.s_ADR, 32'h10);
        chk("pair_s_we", bus.s_WE, 1);
        chk("pair_s_dat_w", bus.s_DAT_W, 32'h1234_5678);
        chk("pair_m_ack", bus.m_ACK, 4'b0001);
        for (int i = 0; i < N; i++)
            chk($sformatf("pair_dat_r%0d", i), bus.m_DAT_R[i*DW +: DW], 32'h10 ^ 32'hCAFE_0000);
        next_cycle();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0; m_adr[0] = home_adr(0);
        @(negedge clk);
        chk("pair_release_gnt", gnt, 4'b0001);
        chk("pair_release_ack", bus.m_ACK, 0);
        next_cycle();
        @(negedge clk);
        chk("pair_dead_gnt", gnt, 0);
        chk("pair_dead_s_cyc", bus.s_CYC, 0);
        next_cycle();
        @(negedge clk);
        chk("pair_gnt1", gnt, 4'b0010);
        chk("pair_gnt1_ack", bus.m_ACK, 4'b0010);
        chk("pair_gnt1_adr", bus.s_ADR, home_adr(1));
        next_cycle();
        m_cyc = '0; m_stb = '0;
        next_cycle();
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;

        // Four masters requesting continuously, single cycles each.
        for (int r = 0; r < 15; r++) begin
            m_cyc = tbl[r].cyc;
            m_stb = tbl[r].cyc;
            exp_q.push_back({tbl[r].exp_gnt, tbl[r].exp_ack});
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("rr_row%0d_gnt_ack", r), {gnt, bus.m_ACK}, e);
            chk($sformatf("rr_row%0d_s_cyc", r), bus.s_CYC, |e[N-1:0]);
            if (|e[N-1:0]) chk($sformatf("rr_row%0d_s_adr", r), bus.s_ADR, exp_adr(e[N-1:0]));
            next_cycle();
        end
        m_cyc = '0; m_stb = '0;
        next_cycle();

        // Master 2 bursts four beats while master 0 waits.
        m_cyc = 4'b0100; m_stb = 4'b0100; m_cti[2] = 3'b010; m_adr[2] = 32'h200;
        @(negedge clk);
        chk("burst_latency_gnt", gnt, 0);
        next_cycle();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        acks = 0;
        for (int b = 0; b < 4; b++) begin
            m_cti[2] = (b == 3) ? 3'b111 : 3'b010;
            m_adr[2] = 32'h200 + 32'(b * 4);
            @(negedge clk);
            chk($sformatf("burst_b%0d_gnt", b), gnt, 4'b0100);
            chk($sformatf("burst_b%0d_ack", b), bus.m_ACK, 4'b0100);
            chk($sformatf("burst_b%0d_cti", b), bus.s_CTI, (b == 3) ? 3'b111 : 3'b010);
            chk($sformatf("burst_b%0d_adr", b), bus.s_ADR, 32'h200 + 32'(b * 4));
            if (bus.m_ACK[2]) acks++;
            next_cycle();
        end
        m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_cti[2] = 3'b000; m_adr[2] = home_adr(2);
        @(negedge clk);
        chk("burst_ack_count", acks, 4);
        chk("burst_end_gnt", gnt, 4'b0100);
        chk("burst_end_ack", bus.m_ACK, 0);
        next_cycle();
        @(negedge clk);
        chk("burst_dead_gnt", gnt, 0);
        next_cycle();
        @(negedge clk);
        chk("burst_m0_gnt", gnt, 4'b0001);
        chk("burst_m0_ack", bus.m_ACK, 4'b0001);
        next_cycle();
        m_cyc = '0; m_stb = '0;
        next_cycle();
        next_cycle();

        // Watchdog: slave never answers master 1.
        ack_en = 1'b0;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        @(negedge clk);
        chk("to_latency_gnt", gnt, 0);
        next_cycle();
        for (int k = 1; k <= TO; k++) begin
            if (k == 2) begin m_cyc[0] = 1'b1; m_stb[0] = 1'b1; end
            @(negedge clk);
            chk($sformatf("to_wait%0d", k), {bus.s_STB, bus.m_ERR, timeout_err}, {1'b1, 4'b0000, 1'b0});
            next_cycle();
        end
        @(negedge clk);
        chk("to_fire_m_err", bus.m_ERR, 4'b0010);
        chk("to_fire_pulse", timeout_err, 1);
        chk("to_fire_s_stb", bus.s_STB, 0);
        chk("to_fire_s_cyc", bus.s_CYC, 0);
        chk("to_fire_gnt", gnt, 4'b0010);
        next_cycle();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        @(negedge clk);
        chk("to_after_m_err", bus.m_ERR, 0);
        chk("to_after_pulse", timeout_err, 0);
        chk("to_hold_gnt", gnt, 4'b0010);
        next_cycle();
        @(negedge clk);
        chk("to_dead_gnt", gnt, 0);
        next_cycle();
        @(negedge clk);
        chk("to_m0_gnt", gnt, 4'b0001);
        next_cycle();
        m_cyc = '0; m_stb = '0;
        next_cycle();
        next_cycle();

        // ACK landing on the expiry cycle wins over the timeout.
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        next_cycle();
        for (int k = 1; k <= TO; k++) next_cycle();
        ack_force = 1'b1;
        @(negedge clk);
        chk("prec_m_ack", bus.m_ACK, 4'b0100);
        chk("prec_m_err", bus.m_ERR, 0);
        chk("prec_pulse", timeout_err, 0);
        next_cycle();
        ack_force = 1'b0;
        @(negedge clk);
        chk("prec_after_pulse", timeout_err, 0);
        chk("prec_after_s_stb", bus.s_STB, 1);
        next_cycle();
        m_cyc = '0; m_stb = '0;
        next_cycle();
        next_cycle();

        // Reset during an outstanding read from master 0.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("mid_rst_gnt_before", gnt, 4'b0001);
        chk("mid_rst_s_cyc_before", bus.s_CYC, 1);
        next_cycle();
        rstn = 1'b0; ack_force = 1'b1; m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
        @(negedge clk);
        chk("mid_rst_s_cyc", bus.s_CYC, 0);
        chk("mid_rst_m_ack", bus.m_ACK, 0);
        next_cycle();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", gnt, 0);
        chk("post_rst_s_cyc", bus.s_CYC, 0);
        chk("post_rst_late_ack", bus.m_ACK, 0);
        chk("post_rst_state", state, 0);
        next_cycle();
        ack_force = 1'b0; err_force = 1'b1;
        @(negedge clk);
        chk("post_rst_m0_gnt", gnt, 4'b0001);
        chk("post_rst_err_route", bus.m_ERR, 4'b0001);
        chk("post_rst_no_pulse", timeout_err, 0);
        next_cycle();
        err_force = 1'b0; m_cyc = '0; m_stb = '0;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
